// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state type, default parameters and width helpers for sram_port_arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam int DEF_NCH = 2;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 64;
  localparam int DEF_TIMEOUT = 255;
  function automatic int cnt_w(input int timeout);
    return timeout > 0 ? $clog2(timeout + 1) : 1;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; i_req/i_ptr in, one-hot o_gnt, index o_idx, o_any when something requested
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % N]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
        o_idx = IW'((int'(i_ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: merges NCH i_ch_req_* ports onto one o_mem_req_*/i_mem_resp_* port, returns o_ch_resp_* pulse, timeout and sticky o_err_unexp_resp
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MW = DW / 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NCH-1:0]    i_ch_req_valid,
  output logic [NCH-1:0]    o_ch_req_ready,
  input  logic [NCH*MW-1:0] i_ch_req_wen,
  input  logic [NCH*AW-1:0] i_ch_req_addr,
  input  logic [NCH*DW-1:0] i_ch_req_wdata,
  output logic [NCH-1:0]    o_ch_resp_valid,
  output logic [DW-1:0]     o_ch_resp_rdata,
  output logic              o_ch_resp_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [MW-1:0]     o_mem_req_wen,
  output logic [AW-1:0]     o_mem_req_addr,
  output logic [DW-1:0]     o_mem_req_wdata,
  input  logic              i_mem_resp_valid,
  input  logic [DW-1:0]     i_mem_resp_rdata,
  output logic              o_err_unexp_resp
);
  localparam int IW = idx_w(NCH);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t          r_state;
  logic [IW-1:0]   r_ptr, r_gidx, w_idx, w_next_ptr;
  logic [NCH-1:0]  w_gnt;
  logic            w_any, w_to;
  logic [CW-1:0]   r_cnt;
  rr_arbiter #(.N(NCH), .IW(IW)) u_rr (
    .i_req(i_ch_req_valid),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  always_comb begin
    w_next_ptr = (w_idx == IW'(NCH - 1)) ? '0 : w_idx + IW'(1);
    w_to = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    o_ch_req_ready = (r_state == IDLE && i_rst_n) ? w_gnt : '0;
    o_mem_req_valid = r_state == REQ;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gidx <= '0;
      r_cnt <= '0;
      o_mem_req_wen <= '0;
      o_mem_req_addr <= '0;
      o_mem_req_wdata <= '0;
      o_ch_resp_valid <= '0;
      o_ch_resp_rdata <= '0;
      o_ch_resp_err <= 1'b0;
      o_err_unexp_resp <= 1'b0;
    end else begin
      o_ch_resp_valid <= '0;
      if (i_mem_resp_valid && r_state != WAIT) o_err_unexp_resp <= 1'b1;
      case (r_state)
        IDLE: if (w_any) begin
          r_gidx <= w_idx;
          r_ptr <= w_next_ptr;
          o_mem_req_wen <= i_ch_req_wen[w_idx*MW +: MW];
          o_mem_req_addr <= i_ch_req_addr[w_idx*AW +: AW];
          o_mem_req_wdata <= i_ch_req_wdata[w_idx*DW +: DW];
          r_state <= REQ;
        end
        REQ: if (i_mem_req_ready) begin
          r_cnt <= '0;
          r_state <= WAIT;
        end
        WAIT: if (i_mem_resp_valid || w_to) begin
          o_ch_resp_valid <= NCH'(1) << r_gidx;
          o_ch_resp_rdata <= i_mem_resp_valid ? i_mem_resp_rdata : '0;
          o_ch_resp_err <= !i_mem_resp_valid;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + CW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
